// File: rtl/pipe_stage_skid.sv
// Width-parametrised pipeline stage with valid/ready handshake and a 2-entry
// skid buffer (main + skid); in_ready_o and out_valid_o come straight from flops.
module pipe_stage_skid #(
  parameter int unsigned DW           = 32,
  parameter bit          CLR_ON_FLUSH = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o,
  output logic [1:0]    occupancy_o
);

  // State bits are the valid flags themselves: bit1 = skid_valid, bit0 = main_valid.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] main_q, skid_q;
  logic          push, pop;
  logic          ld_main_in, ld_main_skid, ld_skid;

  assign push = in_valid_i & in_ready_o & ~flush_i;
  assign pop  = out_valid_o & out_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d    = ONE;
            ld_main_in = 1'b1;
          end
        end
        ONE: begin
          if (push && pop) begin
            ld_main_in = 1'b1;
          end else if (push) begin
            state_d = FULL;
            ld_skid = 1'b1;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_d      = ONE;
            ld_main_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    in_ready_o  = ~state_q[1];
    out_valid_o = state_q[0];
    occupancy_o = {1'b0, state_q[0]} + {1'b0, state_q[1]};
    out_data_o  = main_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (flush_i) begin
      if (CLR_ON_FLUSH) begin
        main_q <= '0;
        skid_q <= '0;
      end
    end else begin
      if (ld_main_in) begin
        main_q <= in_data_i;
      end else if (ld_main_skid) begin
        main_q <= skid_q;
      end
      if (ld_skid) begin
        skid_q <= in_data_i;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: three instances (32b/clear, 8b/clear, 64b/hold) share
// stimulus; a queue-based model plus directed vectors check them.
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] din = '0;

  logic        r32, v32, r8, v8, r64, v64;
  logic [31:0] d32;
  logic [7:0]  d8;
  logic [63:0] d64;
  logic [1:0]  o32, o8, o64;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DW(32), .CLR_ON_FLUSH(1'b1)) u32 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(r32),
    .in_data_i(din[31:0]), .out_valid_o(v32), .out_ready_i(out_ready), .out_data_o(d32),
    .occupancy_o(o32));

  pipe_stage_skid #(.DW(8), .CLR_ON_FLUSH(1'b1)) u8 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(r8),
    .in_data_i(din[7:0]), .out_valid_o(v8), .out_ready_i(out_ready), .out_data_o(d8),
    .occupancy_o(o8));

  pipe_stage_skid #(.DW(64), .CLR_ON_FLUSH(1'b0)) u64 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(r64),
    .in_data_i(din), .out_valid_o(v64), .out_ready_i(out_ready), .out_data_o(d64),
    .occupancy_o(o64));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference: FIFO of at most two entries; "last" is what the main register shows when empty.
  logic [63:0] mq[$];
  logic [63:0] last_clr, last_hold;

  always @(posedge clk or negedge rst_n) begin
    bit push, pop;
    if (!rst_n) begin
      mq.delete();
      last_clr  = '0;
      last_hold = '0;
    end else begin
      push = in_valid && (mq.size() < 2) && !flush;
      pop  = (mq.size() > 0) && out_ready;
      if (flush) begin
        mq.delete();
        last_clr = '0;
      end else begin
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(din);
      end
      if (mq.size() > 0) begin
        last_clr  = mq[0];
        last_hold = mq[0];
      end
    end
  end

  logic        pv, pordy, pfl;
  logic [63:0] pd;

  always @(negedge clk) begin
    logic [63:0] h_c, h_h;
    logic        ev, er;
    logic [1:0]  eo;
    if (!rst_n) begin
      pv = 1'b0;
    end else begin
      ev  = mq.size() > 0;
      er  = mq.size() < 2;
      eo  = 2'(mq.size());
      h_c = ev ? mq[0] : last_clr;
      h_h = ev ? mq[0] : last_hold;
      chk("m32_rdy", {63'd0, r32}, {63'd0, er});
      chk("m32_val", {63'd0, v32}, {63'd0, ev});
      chk("m32_occ", {62'd0, o32}, {62'd0, eo});
      chk("m32_dat", {32'd0, d32}, {32'd0, h_c[31:0]});
      chk("m8_rdy",  {63'd0, r8},  {63'd0, er});
      chk("m8_val",  {63'd0, v8},  {63'd0, ev});
      chk("m8_occ",  {62'd0, o8},  {62'd0, eo});
      chk("m8_dat",  {56'd0, d8},  {56'd0, h_c[7:0]});
      chk("m64_rdy", {63'd0, r64}, {63'd0, er});
      chk("m64_val", {63'd0, v64}, {63'd0, ev});
      chk("m64_occ", {62'd0, o64}, {62'd0, eo});
      chk("m64_dat", d64, h_h);
      // Stalled output must not move.
      if (pv && !pordy && !pfl) begin
        chk("stable_val", {63'd0, v64}, 64'd1);
        chk("stable_dat", d64, pd);
      end
      pv    = v64;
      pordy = out_ready;
      pfl   = flush;
      pd    = d64;
    end
  end

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        fl;
    logic        e_rdy;
    logic        e_v;
    logic [31:0] e_d;
    logic [31:0] e_d_hold;
    logic [1:0]  e_occ;
  } vec_t;

  function automatic vec_t mk(logic iv, logic [31:0] d, logic ordy, logic fl, logic e_rdy,
                              logic e_v, logic [31:0] e_d, logic [31:0] e_dh, logic [1:0] e_occ);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl; v.e_rdy = e_rdy;
    v.e_v = e_v; v.e_d = e_d; v.e_d_hold = e_dh; v.e_occ = e_occ;
    return v;
  endfunction

  vec_t tbl[23];

  initial begin
    // Each row: inputs for the cycle, and the outputs visible during that cycle.
    tbl[0]  = mk(1, 32'h11, 1, 0, 1, 0, 32'h00, 32'h00, 0);
    tbl[1]  = mk(1, 32'h22, 1, 0, 1, 1, 32'h11, 32'h11, 1);
    tbl[2]  = mk(1, 32'h33, 1, 0, 1, 1, 32'h22, 32'h22, 1);
    tbl[3]  = mk(0, 32'h00, 1, 0, 1, 1, 32'h33, 32'h33, 1);
    tbl[4]  = mk(0, 32'h00, 0, 0, 1, 0, 32'h33, 32'h33, 0);
    tbl[5]  = mk(1, 32'hA0, 0, 0, 1, 0, 32'h33, 32'h33, 0);
    tbl[6]  = mk(1, 32'hA1, 0, 0, 1, 1, 32'hA0, 32'hA0, 1);
    tbl[7]  = mk(1, 32'hA2, 0, 0, 0, 1, 32'hA0, 32'hA0, 2);
    tbl[8]  = mk(1, 32'hA2, 0, 0, 0, 1, 32'hA0, 32'hA0, 2);
    tbl[9]  = mk(1, 32'hA2, 1, 0, 0, 1, 32'hA0, 32'hA0, 2);
    tbl[10] = mk(1, 32'hA2, 1, 0, 1, 1, 32'hA1, 32'hA1, 1);
    tbl[11] = mk(0, 32'h00, 1, 0, 1, 1, 32'hA2, 32'hA2, 1);
    tbl[12] = mk(0, 32'h00, 0, 0, 1, 0, 32'hA2, 32'hA2, 0);
    tbl[13] = mk(1, 32'hB0, 0, 0, 1, 0, 32'hA2, 32'hA2, 0);
    tbl[14] = mk(1, 32'hB1, 0, 0, 1, 1, 32'hB0, 32'hB0, 1);
    tbl[15] = mk(1, 32'h55, 0, 1, 0, 1, 32'hB0, 32'hB0, 2);
    tbl[16] = mk(0, 32'h00, 0, 0, 1, 0, 32'h00, 32'hB0, 0);
    tbl[17] = mk(1, 32'hC0, 0, 0, 1, 0, 32'h00, 32'hB0, 0);
    tbl[18] = mk(1, 32'h55, 0, 1, 1, 1, 32'hC0, 32'hC0, 1);
    tbl[19] = mk(0, 32'h00, 0, 0, 1, 0, 32'h00, 32'hC0, 0);
    tbl[20] = mk(1, 32'h77, 0, 0, 1, 0, 32'h00, 32'hC0, 0);
    tbl[21] = mk(0, 32'h00, 1, 1, 1, 1, 32'h77, 32'h77, 1);
    tbl[22] = mk(0, 32'h00, 0, 0, 1, 0, 32'h00, 32'h77, 0);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_rdy", {63'd0, r32}, 64'd1);
      chk("idle_val", {63'd0, v32}, 64'd0);
      chk("idle_dat", {32'd0, d32}, 64'd0);
      chk("idle_occ", {62'd0, o32}, 64'd0);
      @(posedge clk);
      #1;
    end

    for (int i = 0; i < 23; i++) begin
      in_valid  = tbl[i].iv;
      din       = {32'd0, tbl[i].d};
      out_ready = tbl[i].ordy;
      flush     = tbl[i].fl;
      @(negedge clk);
      chk($sformatf("vec%0d_rdy", i), {63'd0, r32}, {63'd0, tbl[i].e_rdy});
      chk($sformatf("vec%0d_val", i), {63'd0, v32}, {63'd0, tbl[i].e_v});
      chk($sformatf("vec%0d_dat", i), {32'd0, d32}, {32'd0, tbl[i].e_d});
      chk($sformatf("vec%0d_occ", i), {62'd0, o32}, {62'd0, tbl[i].e_occ});
      chk($sformatf("vec%0d_hold", i), d64, {32'd0, tbl[i].e_d_hold});
      @(posedge clk);
      #1;
    end

    // Fill to FULL, then assert reset mid-cycle: outputs must clear without an edge.
    in_valid = 1'b1; out_ready = 1'b0; flush = 1'b0; din = 64'hDEAD_0001;
    @(posedge clk); #1 din = 64'hDEAD_0002;
    @(posedge clk); #1 in_valid = 1'b0;
    chk("pre_rst_occ", {62'd0, o32}, 64'd2);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_rdy", {63'd0, r32}, 64'd1);
    chk("arst_val", {63'd0, v32}, 64'd0);
    chk("arst_dat", {32'd0, d32}, 64'd0);
    chk("arst_occ", {62'd0, o64}, 64'd0);
    chk("arst_d64", d64, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(99) < 60);
      out_ready = ($urandom_range(99) < 55);
      flush     = ($urandom_range(63) == 0);
      din       = {$urandom, $urandom};
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Generic, width-parametrised pipeline stage register with a valid/ready handshake and a 2-entry skid buffer (main + skid).
- Successor to the fixed-field stall/flush stage registers between IDU/EXU and other stage boundaries.
- Callers pack arbitrary stage payloads (decode info bus, imm, pc, reg addrs, inst) into one bus.
- Back-pressure replaces the global stall vector. in_ready_o is registered, so there is no combinational ready path across the stage.

Parameters:
- DW, 32: payload width in bits (>=1).
- CLR_ON_FLUSH, 1: 1 = flush zeroes both payload registers; 0 = payload registers hold and only valids clear.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush_i  input  1  synchronous pipeline flush; discards all held entries.
- in_valid_i  input  1  upstream has payload.
- in_ready_o  output  1  stage can accept; registered.
- in_data_i  input  DW  upstream payload.
- out_valid_o  output  1  stage holds payload for downstream; registered.
- out_ready_i  input  1  downstream accepts.
- out_data_o  output  DW  payload of the oldest entry; driven directly from the main register.
- occupancy_o  output  2  number of held entries, 0..2.

Behaviour:
- Reset: asserting rst_n low immediately forces:
  - main_valid=0, skid_valid=0, main/skid data=0.
  - out_valid_o=0, out_data_o=0, in_ready_o=1, occupancy_o=0.
  - Reset mid-transfer drops all entries.
- Handshake terms:
  - push = in_valid_i & in_ready_o & ~flush_i.
  - pop = out_valid_o & out_ready_i.
- Outputs:
  - in_ready_o = ~skid_valid (flop output).
  - out_valid_o = main_valid.
  - occupancy_o = main_valid + skid_valid.
- States (encoded by the valid flags): EMPTY(0/0), ONE(main), FULL(main+skid). skid_valid=1 implies main_valid=1.
- Transitions when flush_i=0:
  - EMPTY: push -> ONE, main<=in_data_i. No push -> stay.
  - ONE: push&pop -> ONE, main<=in_data_i.
  - ONE: push&~pop -> FULL, skid<=in_data_i, main holds.
  - ONE: ~push&pop -> EMPTY. Neither -> hold.
  - FULL: pop -> ONE, main<=skid. ~pop -> hold. push is impossible because in_ready_o=0.
- Latency and throughput:
  - Data accepted at edge N appears on out_data_o after edge N, i.e. 1 cycle.
  - Sustains 1 transfer/cycle while out_ready_i=1.
  - After out_ready_i deasserts, exactly one more beat is absorbed (into the skid), then in_ready_o drops.
- Ordering: strict FIFO; output order equals input order, no duplication or loss except by flush or reset.
- Stability: while out_valid_o=1 and out_ready_i=0, out_data_o and out_valid_o do not change unless flush_i=1.
- Flush (highest priority over all transitions):
  - Next edge: main_valid=0, skid_valid=0, in_ready_o=1.
  - Payload registers go to 0 if CLR_ON_FLUSH=1, otherwise hold.
  - in_valid_i in the flush cycle is discarded.
  - A downstream pop in the flush cycle completes normally. out_valid_o is not gated combinationally; flush acts on the next state only.
- Data-register enables: main loads only on push into EMPTY/ONE-with-pop, or skid->main on pop from FULL. skid loads only on push in ONE without pop. Otherwise both hold.

Test Plan:
- Reset then idle, DW=32: after rst_n rises, in_ready_o=1, out_valid_o=0, out_data_o=0, occupancy_o=0; holds for 10 cycles with in_valid_i=0.
- Streaming, out_ready_i=1, push 0x11,0x22,0x33 on consecutive cycles:
  - Each appears on out_data_o one cycle after acceptance.
  - occupancy_o stays 1; in_ready_o never drops.
- Back-pressure, out_ready_i=0 while pushing 0xA0,0xA1,0xA2:
  - 0xA0 in main, 0xA1 in skid, occupancy_o=2, in_ready_o=0.
  - 0xA2 stays pending on the input, and out_data_o is stable at 0xA0.
  - Raise out_ready_i: outputs 0xA0,0xA1,0xA2 in order with no gaps.
- Flush while FULL, CLR_ON_FLUSH=1:
  - Next cycle out_valid_o=0, occupancy_o=0, in_ready_o=1, out_data_o=0.
  - in_valid_i=1 with 0x55 during the flush cycle is not accepted.
- Flush with simultaneous pop in ONE (main=0x77, out_ready_i=1): the consumer sees 0x77 transferred that cycle; the stage is EMPTY afterwards.
- Random valid/ready for 10k cycles at DW=8 and DW=64, plus CLR_ON_FLUSH=0 flush: a scoreboard confirms order and stability; with CLR_ON_FLUSH=0, after flush out_data_o retains its last value while out_valid_o=0.
